// File: rtl/instr_mem_loader.sv
// Instruction RAM for mips_core: boot-loaded over a valid/ready port, then served
// combinationally by pc while the core is released from reset.
module instr_mem_loader #(
    parameter int unsigned             DEPTH       = 256,
    parameter int unsigned             PC_WIDTH    = 32,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0]  NOP_WORD    = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ld_start,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [INSTR_WIDTH-1:0]     ld_data,
    input  logic                       ld_last,
    output logic                       core_rst_n,
    input  logic [PC_WIDTH-1:0]        pc,
    output logic [INSTR_WIDTH-1:0]     instr,
    output logic                       fetch_err,
    output logic [$clog2(DEPTH):0]     word_count,
    output logic                       load_fault
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = PC_WIDTH - 2;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StFault} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   core_rst_n_q;
    logic                   hs;
    logic [IW-1:0]          idx;
    logic                   in_image;
    logic                   aligned;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    assign hs = (state_q == StLoad) && ld_valid;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (ld_start) begin
                    state_d = StLoad;
                    count_d = '0;
                end
            end
            StLoad: begin
                // ld_start is deliberately ignored here; only handshakes advance the load
                if (hs) begin
                    count_d = count_q + CW'(1);
                    if (ld_last) begin
                        state_d = StRun;
                    end else if (count_q == CW'(DEPTH - 1)) begin
                        state_d = StFault;
                    end
                end
            end
            StRun, StFault: begin
                if (ld_start) begin
                    state_d = StLoad;
                    count_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            count_q      <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            core_rst_n_q <= (state_d == StRun);
        end
    end

    // Contents survive reset; word_count masks anything stale.
    always_ff @(posedge clk) begin
        if (rst_n && hs) begin
            mem[count_q[AW-1:0]] <= ld_data;
        end
    end

    // Full-width compare so high pc bits can never alias into the image.
    assign idx      = pc[PC_WIDTH-1:2];
    assign in_image = idx < IW'(count_q);
    assign aligned  = (pc[1:0] == 2'b00);

    always_comb begin
        instr     = NOP_WORD;
        fetch_err = 1'b0;
        if (state_q == StRun) begin
            if (aligned && in_image) begin
                instr = mem[idx[AW-1:0]];
            end else begin
                fetch_err = 1'b1;
            end
        end
    end

    assign ld_ready   = (state_q == StLoad);
    assign load_fault = (state_q == StFault);
    assign core_rst_n = core_rst_n_q;
    assign word_count = count_q;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Instruction-side responder for mips_core: takes the core's pc and returns instr, one word per address.
- Owns a word-organised instruction RAM filled through a valid/ready boot-load port.
- Holds the core in reset until a program has been fully loaded.
- Flags fetches outside the loaded image or with misaligned pc.

Parameters:
- DEPTH, 256, number of 32-bit instruction words.
- PC_WIDTH, 32, width of pc from the core.
- INSTR_WIDTH, 32, instruction word width.
- NOP_WORD, 32'h0000_0000, word returned whenever no valid instruction exists (sll $0,$0,0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ld_start  in  1  single-cycle pulse; begins a (re)load from word 0.
- ld_valid  in  1  ld_data holds a word to write.
- ld_ready  out  1  block accepts ld_data this cycle.
- ld_data  in  INSTR_WIDTH  instruction word to write.
- ld_last  in  1  qualifies the final word of the image (sampled with ld_valid&&ld_ready).
- core_rst_n  out  1  active-low reset to mips_core; high only in RUN.
- pc  in  PC_WIDTH  byte address from core.
- instr  out  INSTR_WIDTH  fetched instruction.
- fetch_err  out  1  current pc is invalid (RUN only).
- word_count  out  $clog2(DEPTH)+1  number of words in the loaded image.
- load_fault  out  1  image overflowed DEPTH.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-low reset (rst_n), sampled on the rising edge of clk.
- Reset values: state=IDLE, word_count=0, ld_ready=0, core_rst_n=0, load_fault=0, fetch_err=0, instr=NOP_WORD. RAM contents are not cleared by reset; they are masked by word_count.
- States: IDLE, LOAD, RUN, FAULT.
  - IDLE: ld_start -> LOAD, with word_count<=0.
  - LOAD: ld_ready=1 (combinational on state). Handshake when ld_valid&&ld_ready: mem[word_count]<=ld_data, word_count<=word_count+1.
    - Handshake with ld_last=1 -> RUN on the same edge.
    - Handshake with ld_last=0 and word_count==DEPTH-1 (RAM now full) -> FAULT.
    - ld_start in LOAD is ignored.
  - RUN: core_rst_n=1. ld_start -> LOAD (word_count<=0, core_rst_n<=0 on that edge).
  - FAULT: load_fault=1, ld_ready=0, core_rst_n=0. ld_start -> LOAD and clears load_fault.
- Load-port handshake rules:
  - ld_data/ld_last must hold until accepted.
  - ld_valid is ignored outside LOAD.
  - ld_start and ld_valid together in IDLE/RUN/FAULT: only the state change occurs; no word is written.
- core_rst_n is a registered output. It rises on the edge entering RUN, so the core's first fetch (pc=0) happens in the cycle after the last word is accepted.
- Read path is combinational (single-cycle core), word index idx=pc[PC_WIDTH-1:2]:
  - RUN, pc[1:0]==0 and idx<word_count: instr=mem[idx], fetch_err=0.
  - RUN, pc[1:0]!=0 or idx>=word_count: instr=NOP_WORD, fetch_err=1.
  - Any state other than RUN: instr=NOP_WORD, fetch_err=0.
- Width rules:
  - word_count is one bit wider than the index so DEPTH itself is representable.
  - idx is compared at full width; high pc bits are never truncated, so pc>=4*DEPTH always errors.
- Reset mid-load: returns to IDLE, word_count=0, core held in reset. Partial image is discarded logically.
- Reload from RUN: the previous image becomes invisible immediately (word_count=0) while the core is held in reset.

Test Plan:
- Reset, ld_start, 3 words 0x20080005, 0x20090007, 0x01095020 (last on 3rd) -> word_count=3, core_rst_n rises on edge after 3rd handshake, pc=4 gives instr=0x20090007, fetch_err=0.
- In RUN, pc=12 (idx=3>=3) -> instr=0x00000000, fetch_err=1; pc=6 (misaligned) -> NOP, fetch_err=1; pc=0x400 -> NOP, fetch_err=1.
- Backpressure: ld_valid toggled with gaps, ld_start asserted mid-LOAD -> only valid cycles write, word_count unchanged by ld_start, ld_ready=1 throughout LOAD.
- Overflow: DEPTH=4, 4 words with ld_last=0 -> FAULT after 4th, load_fault=1, ld_ready=0, core_rst_n=0; ld_start -> LOAD, load_fault=0, word_count=0.
- Reset mid-load after 2 of 5 words -> IDLE, word_count=0, instr=NOP, core_rst_n=0; following full load of 1 word with ld_last -> RUN, pc=0 returns new word.
- Reload from RUN: ld_start -> core_rst_n=0 next edge, pc=0 gives NOP (fetch_err=0); new 2-word image -> pc=0/4 return new words.
